// File: rtl/regfile_ctrl_pkg.sv
// Shared register-file control constants: default widths, register count,
// the hard-wired zero register and the R-type opcode reused by the decoder.
package regfile_ctrl_pkg;

  localparam int         DEF_ADDR_W = 5;
  localparam int         DEF_DATA_W = 32;
  localparam int         NUM_REGS   = 32;
  localparam logic [4:0] REG_X0     = 5'd0;
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Returns a one-hot grant and its encoded index.
// Build option WB_PRIO_FIXED_EN: lowest asserted index always wins and ptr
// is ignored (plain priority encoder).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

`ifdef WB_PRIO_FIXED_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: first asserted index from 0 upward.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !gnt_vld) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    if (gnt_vld) gnt = NUM_REQ'(1) << gnt_idx;
  end

`else

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       sum;

  // Rotate requests so ptr sits at bit 0, take the first set bit and map its
  // offset back to an absolute index (ptr + offset, wrapped).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_rot[i] && !gnt_vld) begin
        gnt_vld = 1'b1;
        sum     = {1'b0, ptr} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
        gnt_idx = sum[IDX_W-1:0];
      end
    end
    if (gnt_vld) gnt = NUM_REQ'(1) << gnt_idx;
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the register file's single write port.
// Arbitrates NUM_REQ write-back sources, registers the winning write one
// cycle later and keeps a pending-write scoreboard for RAW/WAW stalls.
// Build option WB_PRIO_FIXED_EN: fixed priority instead of round-robin.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         write_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic [IDX_W-1:0]    ptr;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Nothing is accepted while reset is held, so requesters keep their data.
  assign req_ready = reset ? '0 : gnt;
  assign xfer      = gnt_vld & ~reset;
  assign sel_rd    = req_rd[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];

`ifdef WB_PRIO_FIXED_EN
  assign ptr = '0;
`else
  // Priority pointer moves just past the last winner.
  always_ff @(posedge clk) begin
    if (reset)     ptr <= '0;
    else if (xfer) ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  // Write stage: x0 transfers are consumed but never raise the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else begin
      reg_write <= xfer && (sel_rd != X0);
      if (xfer) begin
        rd         <= sel_rd;
        write_data <= sel_data;
      end
    end
  end

  assign issue_ready = ~busy[issue_rd] | (issue_rd == X0);
  assign rs1_busy    = busy[rs1] & (rs1 != X0);
  assign rs2_busy    = busy[rs2] & (rs2 != X0);

  // Scoreboard next state: commit clears first, so a same-edge issue wins.
  always_comb begin
    busy_nxt = busy;
    if (reg_write) busy_nxt[rd] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != X0)) busy_nxt[issue_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

endmodule
